// File: rtl/cic_pkg.sv
// Shared types, saturation limits and rounding helper for the CIC comb chain.
// Optional output rounding/saturation is enabled with the CIC_COMB_ROUND_EN macro.
package cic_pkg;

  localparam int CIC_IN_WIDTH  = 64;
  localparam int CIC_OUT_WIDTH = 24;
  // Widest word the helper functions can describe; IN_WIDTH must not exceed it.
  localparam int CIC_MAX_W     = 128;

  typedef logic signed [CIC_IN_WIDTH-1:0] cic_sample_t;

  localparam logic signed [CIC_OUT_WIDTH-1:0] CIC_SAT_MAX = {1'b0, {(CIC_OUT_WIDTH-1){1'b1}}};
  localparam logic signed [CIC_OUT_WIDTH-1:0] CIC_SAT_MIN = {1'b1, {(CIC_OUT_WIDTH-1){1'b0}}};

  function automatic logic [CIC_MAX_W-1:0] cic_sat_max(input int out_w);
    return (CIC_MAX_W'(1) << (out_w - 1)) - CIC_MAX_W'(1);
  endfunction

  function automatic logic [CIC_MAX_W-1:0] cic_sat_min(input int out_w);
    return ~cic_sat_max(out_w);
  endfunction

  // Half an output LSB expressed in input-word units; zero when no bits are dropped.
  function automatic logic [CIC_MAX_W-1:0] cic_round_offset(input int in_w, input int out_w);
    if (in_w <= out_w) begin
      return '0;
    end
    return CIC_MAX_W'(1) << (in_w - out_w - 1);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One registered comb stage y = x - x_c[n-M] with a separate M-deep history per channel.
// Valid bit and channel tag travel alongside the data; clear drops history and in-flight samples.
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int IN_WIDTH   = 64,
  parameter int DIFF_DELAY = 1,
  parameter int CHANNELS   = 2,
  parameter int CHAN_W     = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                in_valid,
  input  logic [CHAN_W-1:0]   in_chan,
  input  logic [IN_WIDTH-1:0] in_data,
  output logic                out_valid,
  output logic [CHAN_W-1:0]   out_chan,
  output logic [IN_WIDTH-1:0] out_data
);

  logic [IN_WIDTH-1:0] hist_q [CHANNELS][DIFF_DELAY];
  logic                valid_q;
  logic [CHAN_W-1:0]   chan_q;
  logic [IN_WIDTH-1:0] data_q;

  logic [CHANNELS-1:0] hit;
  logic [IN_WIDTH-1:0] oldest;
  logic [IN_WIDTH-1:0] data_d;

  // Channel select by equality compare so an out-of-range tag never indexes the array.
  always_comb begin
    hit    = '0;
    oldest = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (in_valid && (in_chan == CHAN_W'(c))) begin
        hit[c] = 1'b1;
        oldest = hist_q[c][DIFF_DELAY-1];
      end
    end
    data_d = in_data - oldest;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int i = 0; i < DIFF_DELAY; i++) begin
          hist_q[c][i] <= '0;
        end
      end
      valid_q <= 1'b0;
      chan_q  <= '0;
      data_q  <= '0;
    end else if (clear) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int i = 0; i < DIFF_DELAY; i++) begin
          hist_q[c][i] <= '0;
        end
      end
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        chan_q <= in_chan;
        data_q <= data_d;
      end
      for (int c = 0; c < CHANNELS; c++) begin
        if (hit[c]) begin
          hist_q[c][0] <= in_data;
          for (int i = 1; i < DIFF_DELAY; i++) begin
            hist_q[c][i] <= hist_q[c][i-1];
          end
        end
      end
    end
  end

  assign out_valid = valid_q;
  assign out_chan  = chan_q;
  assign out_data  = data_q;

endmodule

// File: rtl/cic_comb_chain.sv
// Time-multiplexed multi-stage CIC comb section followed by output scaling.
// Define CIC_COMB_ROUND_EN for round-half-up with positive saturation (one extra cycle of latency).
module cic_comb_chain
  import cic_pkg::*;
#(
  parameter int IN_WIDTH   = 64,
  parameter int OUT_WIDTH  = 24,
  parameter int STAGES     = 5,
  parameter int DIFF_DELAY = 1,
  parameter int CHANNELS   = 2,
  parameter int CHAN_W     = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_strobe,
  input  logic [CHAN_W-1:0]    in_chan,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_strobe,
  output logic [CHAN_W-1:0]    out_chan,
  output logic [OUT_WIDTH-1:0] out_data
);

  // Strobe semantics: a sample is accepted on any cycle its strobe is high (no
  // backpressure); out_chan/out_data are meaningful only with out_strobe and hold otherwise.
  localparam logic [CHAN_W:0] CH_LIMIT = (CHAN_W+1)'(CHANNELS);

  logic [STAGES:0]     v_w;
  logic [CHAN_W-1:0]   c_w [STAGES+1];
  logic [IN_WIDTH-1:0] d_w [STAGES+1];

  // Samples tagged with a channel that does not exist never enter the pipeline.
  assign v_w[0] = in_strobe && ({1'b0, in_chan} < CH_LIMIT);
  assign c_w[0] = in_chan;
  assign d_w[0] = in_data;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    cic_comb_stage #(
      .IN_WIDTH  (IN_WIDTH),
      .DIFF_DELAY(DIFF_DELAY),
      .CHANNELS  (CHANNELS),
      .CHAN_W    (CHAN_W)
    ) u_stage (
      .clock    (clock),
      .reset    (reset),
      .clear    (clear),
      .in_valid (v_w[g]),
      .in_chan  (c_w[g]),
      .in_data  (d_w[g]),
      .out_valid(v_w[g+1]),
      .out_chan (c_w[g+1]),
      .out_data (d_w[g+1])
    );
  end

`ifdef CIC_COMB_ROUND_EN
  localparam logic [IN_WIDTH-1:0]  ROUND_OFF = IN_WIDTH'(cic_round_offset(IN_WIDTH, OUT_WIDTH));
  localparam logic [OUT_WIDTH-1:0] SAT_MAX   = OUT_WIDTH'(cic_sat_max(OUT_WIDTH));

  logic [IN_WIDTH-1:0]  rounded;
  logic                 overflow;
  logic [OUT_WIDTH-1:0] data_d;
  logic                 strobe_q;
  logic [CHAN_W-1:0]    chan_q;
  logic [OUT_WIDTH-1:0] data_q;

  // Adding a positive offset can only overflow upward: non-negative in, negative out.
  always_comb begin
    rounded  = d_w[STAGES] + ROUND_OFF;
    overflow = !d_w[STAGES][IN_WIDTH-1] && rounded[IN_WIDTH-1];
    data_d   = overflow ? SAT_MAX : rounded[IN_WIDTH-1 -: OUT_WIDTH];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      strobe_q <= 1'b0;
      chan_q   <= '0;
      data_q   <= '0;
    end else if (clear) begin
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= v_w[STAGES];
      if (v_w[STAGES]) begin
        chan_q <= c_w[STAGES];
        data_q <= data_d;
      end
    end
  end

  assign out_strobe = strobe_q;
  assign out_chan   = chan_q;
  assign out_data   = data_q;
`else
  // The last stage register already holds its value between samples.
  assign out_strobe = v_w[STAGES];
  assign out_chan   = c_w[STAGES];
  assign out_data   = d_w[STAGES][IN_WIDTH-1 -: OUT_WIDTH];
`endif

endmodule

// File: tb/tb_cic_comb_chain.sv
// Bench for cic_comb_chain: directed cases on small instances plus a randomized run on a
// multi-channel instance checked against a binomial-expansion reference model.
module tb_cic_comb_chain;

`ifdef CIC_COMB_ROUND_EN
  localparam int XL = 1;
`else
  localparam int XL = 0;
`endif

  localparam int MS  = 5;
  localparam int MM  = 2;
  localparam int MCH = 3;
  localparam int LM  = MS + XL;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic rst;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- main (randomized) instance ----------------
  logic        m_clear, m_strobe;
  logic [1:0]  m_chan;
  logic [63:0] m_data;
  logic        m_os;
  logic [1:0]  m_oc;
  logic [23:0] m_od;

  cic_comb_chain #(.IN_WIDTH(64), .OUT_WIDTH(24), .STAGES(MS), .DIFF_DELAY(MM),
                   .CHANNELS(MCH), .CHAN_W(2)) u_main (
    .clock(clock), .reset(rst), .clear(m_clear), .in_strobe(m_strobe), .in_chan(m_chan),
    .in_data(m_data), .out_strobe(m_os), .out_chan(m_oc), .out_data(m_od));

  // ---------------- small directed instances (shared stimulus) ----------------
  logic        s_clear, s_strobe, s_chan;
  logic [15:0] s_data;
  logic [4:0]  os;
  logic [4:0]  oc;
  logic [15:0] od0, od1, od2;
  logic [7:0]  od3;
  logic [3:0]  od4;

  cic_comb_chain #(.IN_WIDTH(16), .OUT_WIDTH(16), .STAGES(1), .DIFF_DELAY(1),
                   .CHANNELS(1), .CHAN_W(1)) u_d0 (
    .clock(clock), .reset(rst), .clear(s_clear), .in_strobe(s_strobe), .in_chan(s_chan),
    .in_data(s_data), .out_strobe(os[0]), .out_chan(oc[0]), .out_data(od0));
  cic_comb_chain #(.IN_WIDTH(16), .OUT_WIDTH(16), .STAGES(3), .DIFF_DELAY(1),
                   .CHANNELS(1), .CHAN_W(1)) u_d1 (
    .clock(clock), .reset(rst), .clear(s_clear), .in_strobe(s_strobe), .in_chan(s_chan),
    .in_data(s_data), .out_strobe(os[1]), .out_chan(oc[1]), .out_data(od1));
  cic_comb_chain #(.IN_WIDTH(16), .OUT_WIDTH(16), .STAGES(1), .DIFF_DELAY(2),
                   .CHANNELS(2), .CHAN_W(1)) u_d2 (
    .clock(clock), .reset(rst), .clear(s_clear), .in_strobe(s_strobe), .in_chan(s_chan),
    .in_data(s_data), .out_strobe(os[2]), .out_chan(oc[2]), .out_data(od2));
  cic_comb_chain #(.IN_WIDTH(8), .OUT_WIDTH(8), .STAGES(1), .DIFF_DELAY(1),
                   .CHANNELS(1), .CHAN_W(1)) u_d3 (
    .clock(clock), .reset(rst), .clear(s_clear), .in_strobe(s_strobe), .in_chan(s_chan),
    .in_data(s_data[7:0]), .out_strobe(os[3]), .out_chan(oc[3]), .out_data(od3));
  cic_comb_chain #(.IN_WIDTH(8), .OUT_WIDTH(4), .STAGES(1), .DIFF_DELAY(1),
                   .CHANNELS(1), .CHAN_W(1)) u_d4 (
    .clock(clock), .reset(rst), .clear(s_clear), .in_strobe(s_strobe), .in_chan(s_chan),
    .in_data(s_data[7:0]), .out_strobe(os[4]), .out_chan(oc[4]), .out_data(od4));

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Directed-instance output log and expectations
  int got_dat[5][$];
  int got_chn[5][$];
  int got_cyc[5][$];
  int e_dat[$];
  int e_chn[$];
  int e_cyc[$];

  function automatic void log_out(input int k, input int ch, input int d);
    got_dat[k].push_back(d);
    got_chn[k].push_back(ch);
    got_cyc[k].push_back(cyc);
  endfunction

  always @(negedge clock) begin
    if (os[0]) log_out(0, int'(oc[0]), int'($signed(od0)));
    if (os[1]) log_out(1, int'(oc[1]), int'($signed(od1)));
    if (os[2]) log_out(2, int'(oc[2]), int'($signed(od2)));
    if (os[3]) log_out(3, int'(oc[3]), int'($signed(od3)));
    if (os[4]) log_out(4, int'(oc[4]), int'($signed(od4)));
  end

  task automatic exp_out(input int d, input int ch, input int due);
    e_dat.push_back(d);
    e_chn.push_back(ch);
    e_cyc.push_back(due);
  endtask

  task automatic verify(input int k, input string name);
    int n = e_dat.size();
    check({name, "_count"}, 64'(got_dat[k].size()), 64'(n));
    for (int i = 0; i < n && i < got_dat[k].size(); i++) begin
      check({name, "_data"}, got_dat[k][i], e_dat[i]);
      check({name, "_chan"}, got_chn[k][i], e_chn[i]);
      check({name, "_cycle"}, got_cyc[k][i], e_cyc[i]);
    end
    e_dat.delete();
    e_chn.delete();
    e_cyc.delete();
  endtask

  // ---------------- directed drivers ----------------
  task automatic send(input int d, input int ch, input bit clr, input bit stb);
    s_data   = 16'(d);
    s_chan   = ch[0];
    s_clear  = clr;
    s_strobe = stb;
    @(negedge clock);
    s_strobe = 1'b0;
    s_clear  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    for (int k = 0; k < 5; k++) begin
      got_dat[k].delete();
      got_chn[k].delete();
      got_cyc[k].delete();
    end
  endtask

  // ---------------- reference model for the main instance ----------------
  logic [63:0] hist_m[MCH][$];
  logic [23:0] exp_q[$];
  int          exp_chan_q[$];
  int          exp_cyc_q[$];
  logic [23:0] last_d = '0;
  logic [1:0]  last_c = '0;

  function automatic int binom(input int n, input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  function automatic logic [23:0] scale24(input logic [63:0] y);
`ifdef CIC_COMB_ROUND_EN
    logic [63:0] r = y + (64'd1 << 39);
    if (!y[63] && r[63]) return 24'h7FFFFF;
    return r[63:40];
`else
    return y[63:40];
`endif
  endfunction

  // Discard expectations whose output would appear after cycle n.
  task automatic drop_after(input int n);
    while (exp_cyc_q.size() > 0 && exp_cyc_q[exp_cyc_q.size()-1] > n) begin
      void'(exp_q.pop_back());
      void'(exp_chan_q.pop_back());
      void'(exp_cyc_q.pop_back());
    end
  endtask

  // (1 - z^-M)^S over each channel's own sample sequence, modulo 2^64.
  task automatic model_step(input int n);
    int ch;
    logic [63:0] y, x, term;
    if (m_clear) begin
      drop_after(n);
      for (int c = 0; c < MCH; c++) hist_m[c].delete();
    end else if (m_strobe && int'(m_chan) < MCH) begin
      ch = int'(m_chan);
      hist_m[ch].push_front(m_data);
      if (hist_m[ch].size() > MS * MM + 1) void'(hist_m[ch].pop_back());
      y = '0;
      for (int j = 0; j <= MS; j++) begin
        x    = (j * MM < hist_m[ch].size()) ? hist_m[ch][j*MM] : 64'd0;
        term = 64'(binom(MS, j)) * x;
        y    = (j % 2 == 1) ? y - term : y + term;
      end
      exp_q.push_back(scale24(y));
      exp_chan_q.push_back(ch);
      exp_cyc_q.push_back(n + LM);
    end
  endtask

  // Scoreboard for the main instance
  always @(negedge clock) begin
    if (m_os) begin
      if (exp_q.size() == 0) begin
        check("m_spurious_strobe", 64'(m_os), 64'd0);
      end else begin
        check("m_data", 64'(m_od), 64'(exp_q.pop_front()));
        check("m_chan", 64'(m_oc), 64'(exp_chan_q.pop_front()));
        check("m_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
      end
      last_d = m_od;
      last_c = m_oc;
    end else begin
      check("m_hold_data", 64'(m_od), 64'(last_d));
      check("m_hold_chan", 64'(m_oc), 64'(last_c));
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
        check("m_missing_strobe", 64'(m_os), 64'd1);
        void'(exp_q.pop_front());
        void'(exp_chan_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
    end
  end

  task automatic mid_reset();
    m_strobe = 1'b0;
    m_clear  = 1'b0;
    @(posedge clock);
    #2;
    rst = 1'b1;
    drop_after(cyc - 1);
    for (int c = 0; c < MCH; c++) hist_m[c].delete();
    last_d = '0;
    last_c = '0;
    #1;
    check("async_rst_strobe", 64'(m_os), 64'd0);
    check("async_rst_chan", 64'(m_oc), 64'd0);
    check("async_rst_data", 64'(m_od), 64'd0);
    @(negedge clock);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int din3[9]  = '{0, 7, 1, 7, 2, 7, 3, 7, 4};
    int dch3[9]  = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
    int dex3[9]  = '{0, 7, 1, 7, 2, 0, 2, 0, 2};
    int imp2[5]  = '{1, 0, 0, 0, 0};
    int res2[5]  = '{1, -3, 3, -1, 0};

    rst = 1'b0;
    s_clear = 1'b0; s_strobe = 1'b0; s_chan = 1'b0; s_data = '0;
    m_clear = 1'b0; m_strobe = 1'b0; m_chan = '0; m_data = '0;
    #2 rst = 1'b1;
    idle(2);
    check("reset_m_strobe", 64'(m_os), 64'd0);
    check("reset_m_chan", 64'(m_oc), 64'd0);
    check("reset_m_data", 64'(m_od), 64'd0);
    check("reset_s_strobe", 64'(os), 64'd0);
    check("reset_s_data", {od0, od1, od2, od3, od4, 4'd0}, 64'd0);
    rst = 1'b0;
    idle(1);

    // Single stage, M=1; a sample on a nonexistent channel must leave no trace.
    do_reset();
    send(77, 1, 1'b0, 1'b1);
    idle(3);
    exp_out(5, 0, cyc + 1 + XL);  send(5, 0, 1'b0, 1'b1);
    exp_out(3, 0, cyc + 1 + XL);  send(8, 0, 1'b0, 1'b1);
    exp_out(12, 0, cyc + 1 + XL); send(20, 0, 1'b0, 1'b1);
    idle(4);
    verify(0, "t1_single");

    // Three stages, impulse response.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp_out(res2[i], 0, cyc + 3 + XL);
      send(imp2[i], 0, 1'b0, 1'b1);
    end
    idle(6);
    verify(1, "t2_impulse");

    // Two channels, M=2, interleaved.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      exp_out(dex3[i], dch3[i], cyc + 1 + XL);
      send(din3[i], dch3[i], 1'b0, 1'b1);
    end
    idle(4);
    verify(2, "t3_two_chan");

    // Integrator wrap in an 8-bit word.
    do_reset();
    exp_out(127, 0, cyc + 1 + XL); send(127, 0, 1'b0, 1'b1);
    exp_out(1, 0, cyc + 1 + XL);   send(-128, 0, 1'b0, 1'b1);
    idle(4);
    verify(3, "t4_wrap");

    // Clear with a simultaneous strobe kills in-flight data and history.
    do_reset();
    send(10, 0, 1'b0, 1'b1);
    send(20, 0, 1'b0, 1'b1);
    send(99, 0, 1'b1, 1'b1);
    idle(6);
    exp_out(42, 0, cyc + 3 + XL); send(42, 0, 1'b0, 1'b1);
    idle(6);
    verify(1, "t5_clear");

    // Output scaling 8 -> 4 bits.
    do_reset();
`ifdef CIC_COMB_ROUND_EN
    exp_out(2, 0, cyc + 1 + XL); send(8'h18, 0, 1'b0, 1'b1);
`else
    exp_out(1, 0, cyc + 1 + XL); send(8'h18, 0, 1'b0, 1'b1);
`endif
    idle(4);
    send(0, 0, 1'b1, 1'b0);
    idle(2);
    exp_out(7, 0, cyc + 1 + XL); send(8'h7F, 0, 1'b0, 1'b1);
    idle(4);
    verify(4, "t6_scale");

    // Randomized multi-channel run with clears and one asynchronous reset.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (i == 400) mid_reset();
      m_clear  = ($urandom_range(0, 39) == 0);
      m_strobe = ($urandom_range(0, 3) != 0);
      m_chan   = 2'($urandom_range(0, 3));
      m_data   = {$urandom, $urandom};
      model_step(cyc);
      @(negedge clock);
    end
    m_strobe = 1'b0;
    m_clear  = 1'b0;
    idle(LM + 3);
    check("m_drain", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
